// File: rtl/servo_multi_ctrl.sv
// N-channel joystick-to-servo controller: clamp, exact linear map (sequential divide),
// per-frame slew limit and 50 Hz PWM. Optional centre deadband: SERVO_MULTI_CTRL_DEADBAND_EN.
module servo_multi_ctrl #(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned CLK_HZ    = 12_000_000,
    parameter int unsigned IN_W      = 10,
    parameter int unsigned IN_MIN    = 228,
    parameter int unsigned IN_MAX    = 830,
    parameter int unsigned PW_MIN_US = 650,
    parameter int unsigned PW_MAX_US = 2600,
    parameter int unsigned FRAME_US  = 20000,
    parameter int unsigned SLEW_US   = 40,
    parameter int unsigned DEADBAND  = 16
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [CHANNELS*IN_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CHANNELS-1:0]      enable,
    output logic [CHANNELS-1:0]      pwm,
    output logic [CHANNELS*16-1:0]   pw_us,
    output logic                     frame_start
);

    localparam int unsigned PRESC   = CLK_HZ / 1_000_000;
    localparam int unsigned SPAN_IN = IN_MAX - IN_MIN;
    localparam int unsigned SPAN_PW = PW_MAX_US - PW_MIN_US;
    localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [15:0] CENTER  = 16'((PW_MIN_US + PW_MAX_US) / 2);
    localparam logic signed [16:0] SLEW_S = 17'(SLEW_US);

    typedef enum logic [1:0] {StIdle, StLoad, StDiv, StStore} state_e;

    state_e                    state_q, state_d;
    logic                      ready_q;
    logic [CHANNELS*IN_W-1:0]  data_q;
    logic [CH_W-1:0]           ch_q;
    logic [4:0]                bit_q;
    logic [32:0]               rem_q;
    logic [31:0]               quo_q;
    logic [15:0]               target_q [CHANNELS];
    logic [15:0]               pw_q     [CHANNELS];
    logic [15:0]               pw_nxt   [CHANNELS];
    logic signed [16:0]        diff     [CHANNELS];
    logic [31:0]               presc_q, us_q;
    logic                      first_q, fs_q, tick;
    logic [CHANNELS-1:0]       pwm_q;

    logic [IN_W-1:0] raw;
    logic [31:0]     clamped, num;
    logic [32:0]     rem_sh;
    logic            ge;

    wire accept = in_valid && ready_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StLoad;
            StLoad:  state_d = StDiv;
            StDiv:   if (bit_q == 5'd31) state_d = StStore;
            StStore: state_d = (ch_q == CH_W'(CHANNELS - 1)) ? StIdle : StLoad;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        raw     = data_q[ch_q*IN_W +: IN_W];
        clamped = 32'(raw);
        if (clamped < IN_MIN)      clamped = IN_MIN;
        else if (clamped > IN_MAX) clamped = IN_MAX;
`ifdef SERVO_MULTI_CTRL_DEADBAND_EN
        // Snap near-centre samples so a resting stick maps exactly to CENTER.
        if ((clamped + DEADBAND >= (IN_MIN + IN_MAX) / 2) &&
            (clamped <= (IN_MIN + IN_MAX) / 2 + DEADBAND)) begin
            clamped = (IN_MIN + IN_MAX) / 2;
        end
`endif
        num    = (clamped - IN_MIN) * SPAN_PW;
        rem_sh = {rem_q[31:0], quo_q[31]};
        ge     = (rem_sh >= 33'(SPAN_IN));
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ready_q <= 1'b1;
            data_q  <= '0;
            ch_q    <= '0;
            bit_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            for (int i = 0; i < CHANNELS; i++) target_q[i] <= CENTER;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        data_q  <= in_data;
                        ready_q <= 1'b0;
                        ch_q    <= '0;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                StLoad: begin
                    rem_q <= '0;
                    quo_q <= num;
                    bit_q <= '0;
                end
                StDiv: begin
                    // Quotient bits shift in as dividend bits shift out of quo_q.
                    rem_q <= ge ? (rem_sh - 33'(SPAN_IN)) : rem_sh;
                    quo_q <= {quo_q[30:0], ge};
                    bit_q <= bit_q + 5'd1;
                end
                StStore: begin
                    target_q[ch_q] <= 16'(PW_MIN_US + quo_q);
                    ch_q           <= ch_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign tick = (presc_q == PRESC - 1);

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            diff[i]   = $signed({1'b0, target_q[i]}) - $signed({1'b0, pw_q[i]});
            pw_nxt[i] = target_q[i];
            if (SLEW_US != 0) begin
                if (diff[i] > SLEW_S)       pw_nxt[i] = pw_q[i] + 16'(SLEW_US);
                else if (diff[i] < -SLEW_S) pw_nxt[i] = pw_q[i] - 16'(SLEW_US);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            presc_q <= '0;
            us_q    <= '0;
            first_q <= 1'b1;
            fs_q    <= 1'b0;
            pwm_q   <= '0;
            for (int i = 0; i < CHANNELS; i++) pw_q[i] <= CENTER;
        end else begin
            presc_q <= tick ? '0 : presc_q + 32'd1;
            if (tick) begin
                us_q    <= (us_q == FRAME_US - 1) ? '0 : us_q + 32'd1;
                first_q <= 1'b0;
            end
            fs_q <= tick && (first_q || (us_q == FRAME_US - 1));
            // Pulse widths only move at frame start so every pulse is whole.
            if (fs_q) begin
                for (int i = 0; i < CHANNELS; i++) pw_q[i] <= pw_nxt[i];
            end
            for (int i = 0; i < CHANNELS; i++) begin
                pwm_q[i] <= enable[i] && (us_q < 32'(pw_q[i]));
            end
        end
    end

    always_comb begin
        pw_us = '0;
        for (int i = 0; i < CHANNELS; i++) pw_us[i*16 +: 16] = pw_q[i];
    end

    assign in_ready    = ready_q;
    assign pwm         = pwm_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_servo_multi_ctrl.sv
// Bench for servo_multi_ctrl: three instances sharing stimulus with SLEW_US = 0, 40 and 400,
// shortened timebase (2 MHz clock, 2700 us frame).
module tb_servo_multi_ctrl;

    localparam int unsigned FRAME_CYC = 5400;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [39:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic [3:0]  enable = 4'hF;

    logic        in_ready_a, in_ready_b, in_ready_c;
    logic        fs_a, fs_b, fs_c;
    logic [3:0]  pwm_a, pwm_b, pwm_c;
    logic [63:0] pw_a, pw_b, pw_c;

    int total = 0;
    int bad = 0;
    bit mon_en = 1'b0;
    int pwm2_hits = 0;

    always #5 CLK = ~CLK;

    servo_multi_ctrl #(.CLK_HZ(2_000_000), .FRAME_US(2700), .SLEW_US(0)) dut_a (
        .CLK(CLK), .RST_N(RST_N), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_a), .enable(enable), .pwm(pwm_a), .pw_us(pw_a),
        .frame_start(fs_a)
    );
    servo_multi_ctrl #(.CLK_HZ(2_000_000), .FRAME_US(2700), .SLEW_US(40)) dut_b (
        .CLK(CLK), .RST_N(RST_N), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_b), .enable(enable), .pwm(pwm_b), .pw_us(pw_b),
        .frame_start(fs_b)
    );
    servo_multi_ctrl #(.CLK_HZ(2_000_000), .FRAME_US(2700), .SLEW_US(400)) dut_c (
        .CLK(CLK), .RST_N(RST_N), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_c), .enable(enable), .pwm(pwm_c), .pw_us(pw_c),
        .frame_start(fs_c)
    );

    always @(negedge CLK) begin
        if (mon_en && (pwm_a[2] || pwm_b[2] || pwm_c[2])) pwm2_hits++;
    end

    typedef struct {
        logic [39:0] data;  // {ch3, ch2, ch1, ch0}
        logic [63:0] exp;   // {ch3, ch2, ch1, ch0}
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic int pw_of(input logic [63:0] v, input int ch);
        return int'(v[ch*16 +: 16]);
    endfunction

    task automatic wait_fs();
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!fs_a && n < 2 * FRAME_CYC);
        if (!fs_a) begin
            total++;
            bad++;
            $display("FAIL frame_start timeout: got none after %0d cycles, want one", n);
        end
        @(negedge CLK);
    endtask

    task automatic send(input logic [39:0] d, input bit chk_lat);
        int n = 0;
        @(negedge CLK);
        in_data  = d;
        in_valid = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0;
        while (!in_ready_a && n < 400) begin
            @(negedge CLK);
            n++;
        end
        if (chk_lat) check("accept_to_ready", n, 137);
    endtask

    initial begin
        vec_t vecs[3];
        int   cnt[4];
        int   n;
        int   exp_b0[4], exp_b1[4], exp_c0[4], exp_c1[4];
        logic [39:0] x_set, y_set;

        vecs[0].data = {10'd1023, 10'd100, 10'd830, 10'd228};
        vecs[0].exp  = {16'd2600, 16'd650, 16'd2600, 16'd650};
`ifdef SERVO_MULTI_CTRL_DEADBAND_EN
        vecs[1].exp  = {16'd2178, 16'd1625, 16'd1725, 16'd1625};
`else
        vecs[1].exp  = {16'd2178, 16'd1625, 16'd1725, 16'd1660};
`endif
        vecs[1].data = {10'd700, 10'd529, 10'd560, 10'd540};
        vecs[2].data = {10'd600, 10'd229, 10'd829, 10'd300};
        vecs[2].exp  = {16'd1854, 16'd653, 16'd2596, 16'd883};
        exp_b0 = '{1665, 1705, 1745, 1785};
        exp_b1 = '{1585, 1545, 1505, 1465};
        exp_c0 = '{2025, 2425, 2600, 2600};
        exp_c1 = '{1225, 825, 650, 650};

        // Reset state
        repeat (3) @(negedge CLK);
        check("reset_in_ready", int'(in_ready_a), 1);
        check("reset_frame_start", int'(fs_a), 0);
        check("reset_pwm", int'(pwm_a), 0);
        for (int ch = 0; ch < 4; ch++) check($sformatf("reset_pw%0d", ch), pw_of(pw_a, ch), 1625);
        RST_N = 1'b1;

        // Idle duty: 1625 us of each 2700 us frame at 2 cycles/us
        repeat (10) @(negedge CLK);
        cnt = '{0, 0, 0, 0};
        for (int c = 0; c < FRAME_CYC; c++) begin
            @(negedge CLK);
            for (int ch = 0; ch < 4; ch++) if (pwm_a[ch]) cnt[ch]++;
        end
        for (int ch = 0; ch < 4; ch++) check($sformatf("idle_high_cycles%0d", ch), cnt[ch], 3250);

        // Mapping table through the unlimited-slew instance
        wait_fs();
        for (int v = 0; v < 3; v++) begin
            send(vecs[v].data, 1'b1);
            wait_fs();
            for (int ch = 0; ch < 4; ch++) begin
                check($sformatf("map_v%0d_ch%0d", v, ch), pw_of(pw_a, ch),
                      int'(vecs[v].exp[ch*16 +: 16]));
            end
        end

        // Busy handshake: data changed while busy must be dropped
        x_set = {10'd829, 10'd300, 10'd700, 10'd560};
        y_set = {4{10'd1023}};
        @(negedge CLK);
        in_data  = x_set;
        in_valid = 1'b1;
        @(negedge CLK);
        in_data = y_set;
        repeat (100) @(negedge CLK);
        check("busy_ready_low", int'(in_ready_a), 0);
        in_valid = 1'b0;
        n = 0;
        while (!in_ready_a && n < 400) begin
            @(negedge CLK);
            n++;
        end
        wait_fs();
        check("busy_ch0", pw_of(pw_a, 0), 1725);
        check("busy_ch1", pw_of(pw_a, 1), 2178);
        check("busy_ch2", pw_of(pw_a, 2), 883);
        check("busy_ch3", pw_of(pw_a, 3), 2596);

        // Slew from reset, channel 2 disabled
        @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N  = 1'b1;
        enable = 4'b1011;
        mon_en = 1'b1;
        wait_fs();
        send({10'd529, 10'd830, 10'd228, 10'd830}, 1'b0);
        for (int f = 0; f < 4; f++) begin
            wait_fs();
            check($sformatf("slew40_ch0_f%0d", f + 1), pw_of(pw_b, 0), exp_b0[f]);
            check($sformatf("slew40_ch1_f%0d", f + 1), pw_of(pw_b, 1), exp_b1[f]);
            check($sformatf("slew40_ch2_f%0d", f + 1), pw_of(pw_b, 2), exp_b0[f]);
            check($sformatf("slew400_ch0_f%0d", f + 1), pw_of(pw_c, 0), exp_c0[f]);
            check($sformatf("slew400_ch1_f%0d", f + 1), pw_of(pw_c, 1), exp_c1[f]);
            check($sformatf("slew400_ch3_f%0d", f + 1), pw_of(pw_c, 3), 1625);
            if (f == 0) begin
                repeat (4) @(negedge CLK);
                check("enable_pwm_on", int'(pwm_c[0]), 1);
                enable[0] = 1'b0;
                @(negedge CLK);
                check("enable_cleared_pwm_off", int'(pwm_c[0]), 0);
                enable[0] = 1'b1;
                @(negedge CLK);
                check("enable_restored_pwm_on", int'(pwm_c[0]), 1);
            end
        end
        mon_en = 1'b0;
        check("disabled_ch2_pwm_high_cycles", pwm2_hits, 0);
        check("noslew_ch0", pw_of(pw_a, 0), 2600);
        check("noslew_ch1", pw_of(pw_a, 1), 650);

        // Reset in the middle of a divide
        enable = 4'hF;
        @(negedge CLK);
        in_data  = {4{10'd830}};
        in_valid = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0;
        repeat (10) @(negedge CLK);
        check("middiv_busy", int'(in_ready_a), 0);
        RST_N = 1'b0;
        #1;
        check("middiv_rst_ready", int'(in_ready_a), 1);
        check("middiv_rst_pwm", int'(pwm_a), 0);
        check("middiv_rst_fs", int'(fs_a), 0);
        for (int ch = 0; ch < 4; ch++) check($sformatf("middiv_rst_pw%0d", ch), pw_of(pw_a, ch), 1625);
        @(negedge CLK);
        RST_N = 1'b1;
        wait_fs();
        wait_fs();
        for (int ch = 0; ch < 4; ch++) check($sformatf("after_rst_pw%0d", ch), pw_of(pw_a, ch), 1625);
        check("after_rst_ready", int'(in_ready_a), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
